// File: rtl/gcd_input_ctrl.sv
// gcd_input_ctrl: conditions the start button and captures operands for one GCD run per press.
// Optional build macro ZERO_CHECK_EN rejects zero operands and raises err instead of launching.
module gcd_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         btn_start,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic         gcd_done,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         start_out,
    output logic         busy,
    output logic         err
);
    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic          sync1, btn_s;
    logic [1:0]    fill;
    logic          armed;
    logic          db, db_q;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic [1:0]    state, state_d;
    logic [W-1:0]  x_d, y_d;
    logic          busy_d, err_d;
    logic          press, compl, zero_ops;

    // fill marks when btn_s carries real samples again after reset; armed then waits for a
    // released button so a button held through reset cannot launch.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= btn_start;
            btn_s <= sync1;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && !btn_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            db_q   <= db;
            done_q <= gcd_done;
            if (btn_s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = db & ~db_q & armed;
    assign compl = gcd_done & ~done_q;

`ifdef ZERO_CHECK_EN
    assign zero_ops = (x_in == '0) || (y_in == '0);
`else
    assign zero_ops = 1'b0;
`endif

    always_comb begin
        state_d = state;
        x_d     = x_out;
        y_d     = y_out;
        busy_d  = busy;
        err_d   = err;
        case (state)
            IDLE: begin
                if (press) begin
                    x_d = x_in;
                    y_d = y_in;
                    if (zero_ops) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                // Completion wins over a simultaneous press, which is simply dropped.
                if (compl) begin
                    busy_d  = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!db) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            x_out <= '0;
            y_out <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            x_out <= x_d;
            y_out <= y_d;
            busy  <= busy_d;
            err   <= err_d;
        end
    end

    assign start_out = (state == LAUNCH);

endmodule

// File: tb/tb_gcd_input_ctrl.sv
// Self-checking bench for gcd_input_ctrl: directed scenarios plus random button/done traffic,
// compared every cycle against a behavioural model of the press-to-launch protocol.
module tb_gcd_input_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned W  = 8;

    logic         CLK = 1'b0;
    logic         reset;
    logic         btn_start;
    logic [W-1:0] x_in, y_in;
    logic         gcd_done;
    logic [W-1:0] x_out, y_out;
    logic         start_out, busy, err;

    gcd_input_ctrl #(.DEBOUNCE_CYCLES(DB), .W(W)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .btn_start (btn_start),
        .x_in      (x_in),
        .y_in      (y_in),
        .gcd_done  (gcd_done),
        .x_out     (x_out),
        .y_out     (y_out),
        .start_out (start_out),
        .busy      (busy),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;
    int pulses  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: button seen two cycles late, level accepted after DB consecutive
    // disagreeing samples, then a four-phase protocol (0 idle, 1 launch, 2 wait, 3 hold).
    bit           pipe[$];
    bit           m_db, m_db_prev, m_done_prev, m_armed, m_busy, m_err;
    int           m_run, m_mode, m_age;
    logic [W-1:0] m_x, m_y;

    task automatic model_reset();
        pipe = {1'b0, 1'b0};
        m_db = 0; m_db_prev = 0; m_done_prev = 0; m_armed = 0; m_busy = 0; m_err = 0;
        m_run = 0; m_mode = 0; m_age = 0; m_x = '0; m_y = '0;
    endtask

    task automatic model_step();
        bit lvl, press, compl, zero;
        lvl   = pipe[0];
        press = m_db && !m_db_prev && m_armed;
        compl = gcd_done && !m_done_prev;
        zero  = 0;
`ifdef ZERO_CHECK_EN
        zero  = (x_in == 0) || (y_in == 0);
`endif
        if (m_mode == 0 && press) begin
            m_x = x_in;
            m_y = y_in;
            m_err  = zero;
            m_busy = !zero;
            m_mode = zero ? 3 : 1;
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 2 && compl) begin
            m_busy = 0;
            m_mode = 3;
        end else if (m_mode == 3 && !m_db) begin
            m_mode = 0;
        end
        if (m_age >= 2 && !lvl) m_armed = 1;
        m_db_prev = m_db;
        if (lvl != m_db) begin
            if (m_run == int'(DB) - 1) begin
                m_db  = !m_db;
                m_run = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
        m_done_prev = gcd_done;
        pipe.push_back(btn_start);
        void'(pipe.pop_front());
        m_age++;
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (reset) model_reset();
        else model_step();
        @(negedge CLK);
        check_eq("start", 32'(start_out), 32'(m_mode == 1));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("x_out", 32'(x_out), 32'(m_x));
        check_eq("y_out", 32'(y_out), 32'(m_y));
        if (start_out) pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_start(input int max, output int idx);
        idx = 0;
        for (int i = 1; i <= max; i++) begin
            cycle();
            if (start_out === 1'b1) begin
                idx = i;
                break;
            end
        end
    endtask

    int idx;
    int len;
    bit lvl;

    initial begin
        reset = 1'b1; btn_start = 1'b0; x_in = '0; y_in = '0; gcd_done = 1'b0;
        model_reset();
        #1;
        check_eq("rst_x", 32'(x_out), 0);
        check_eq("rst_y", 32'(y_out), 0);
        check_eq("rst_start", 32'(start_out), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_err", 32'(err), 0);
        run(3);
        reset = 1'b0;
        run(5);

        // Bounce shorter than the debounce window must never launch.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn_start = (i % 4) < 2;
            cycle();
        end
        btn_start = 1'b0;
        run(10);
        check_eq("bounce_pulses", 32'(pulses), 0);
        check_eq("bounce_busy", 32'(busy), 0);

        // Clean launch: 2 sync + DB debounce + 1 FSM edge.
        x_in = 8'd36; y_in = 8'd24; btn_start = 1'b1;
        wait_start(20, idx);
        check_eq("launch_lat", 32'(idx), 7);
        check_eq("launch_x", 32'(x_out), 36);
        check_eq("launch_y", 32'(y_out), 24);
        check_eq("launch_busy", 32'(busy), 1);

        // Re-press during WAIT is ignored.
        pulses = 0;
        x_in = 8'd99; btn_start = 1'b0;
        run(8);
        btn_start = 1'b1;
        run(8);
        check_eq("lock_pulses", 32'(pulses), 0);
        check_eq("lock_x", 32'(x_out), 36);
        gcd_done = 1'b1;
        cycle();
        check_eq("done_busy", 32'(busy), 0);

        // Button held through completion: no relaunch; gcd_done stays high (stale).
        pulses = 0;
        run(15);
        check_eq("hold_pulses", 32'(pulses), 0);
        btn_start = 1'b0;
        run(10);
        x_in = 8'd10; y_in = 8'd4; btn_start = 1'b1;
        wait_start(20, idx);
        check_eq("relaunch_lat", 32'(idx), 7);
        check_eq("relaunch_x", 32'(x_out), 10);
        run(10);
        check_eq("stale_busy", 32'(busy), 1);
        gcd_done = 1'b0;
        run(2);
        gcd_done = 1'b1;
        cycle();
        check_eq("done2_busy", 32'(busy), 0);
        gcd_done = 1'b0;

        // Zero operand.
        btn_start = 1'b0;
        run(10);
        x_in = 8'd0; y_in = 8'd9; btn_start = 1'b1;
        pulses = 0;
        run(12);
`ifdef ZERO_CHECK_EN
        check_eq("zero_pulses", 32'(pulses), 0);
        check_eq("zero_err", 32'(err), 1);
        check_eq("zero_busy", 32'(busy), 0);
`else
        check_eq("zero_pulses", 32'(pulses), 1);
        check_eq("zero_x", 32'(x_out), 0);
        check_eq("zero_y", 32'(y_out), 9);
        gcd_done = 1'b1;
        cycle();
        gcd_done = 1'b0;
`endif
        btn_start = 1'b0;
        run(10);

        // Reset in WAIT with the button held.
        x_in = 8'd20; y_in = 8'd15; btn_start = 1'b1;
        wait_start(20, idx);
        check_eq("pre_rst_found", 32'(idx != 0), 1);
        run(3);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_x", 32'(x_out), 0);
        check_eq("arst_y", 32'(y_out), 0);
        check_eq("arst_start", 32'(start_out), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_err", 32'(err), 0);
        cycle();
        reset = 1'b0;
        pulses = 0;
        run(20);
        check_eq("held_after_rst", 32'(pulses), 0);
        btn_start = 1'b0;
        run(10);
        btn_start = 1'b1;
        wait_start(20, idx);
        check_eq("post_rst_lat", 32'(idx), 7);

        // Random traffic: bursts of bounce and stable levels, toggling done, occasional zeros.
        for (int s = 0; s < 150; s++) begin
            len = $urandom_range(1, 20);
            lvl = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                btn_start = (len < 5) ? 1'($urandom_range(0, 1)) : lvl;
                if ($urandom_range(0, 7) == 0) gcd_done = !gcd_done;
                if ($urandom_range(0, 3) == 0) begin
                    x_in = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                    y_in = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                end
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
